eret_ctrl: RTL
==============

ERET_CTRL -- requirements
Module: eret_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: id_eret  input  1  ERET decoded in ID stage.
REQ-004 SHALL have port: exc_req  input  1  exception entry accepted this cycle.
REQ-005 SHALL have port: epc_in  input  32  EPC value selected by the exception-entry EPC mux.
REQ-006 SHALL have port: stall  input  1  pipeline stall; freezes drain counting.
REQ-007 SHALL have ports: mtc0_we  input  1; mtc0_addr  input  5; mtc0_data  input  32  CP0 write.
REQ-008 SHALL have ports: mfc0_addr  input  5; mfc0_data  output  32  combinational CP0 read.
REQ-009 SHALL have ports: EXL  output  1; IE  output  1; EPC_out  output  32  CP0 state.
REQ-010 SHALL have ports: pc_redirect  output  1; redirect_pc  output  32  return-jump request.
REQ-011 SHALL have ports: flush_if  output  1; flush_id  output  1; eret_busy  output  1.

Function
REQ-012 SHALL hold CP0 registers: Status (addr 12, bit1 EXL, bit0 IE, other bits read 0) and EPC (addr 14); other addresses read 0 and ignore writes.
REQ-013 SHALL, on exc_req, load EPC <= epc_in and set EXL <= 1 at the next edge.
REQ-014 SHALL apply register-write priority per edge: exc_req > ERET EXL-clear > mtc0 write.
REQ-015 SHALL implement FSM states IDLE, DRAIN, REDIRECT.
REQ-016 SHALL, in IDLE with id_eret=1 and exc_req=0, assert flush_if that cycle, enter DRAIN with drain counter = 2.
REQ-017 SHALL, in DRAIN, decrement counter on each cycle with stall=0, hold on stall=1; move to REDIRECT when counter reaches 0.
REQ-018 SHALL, in REDIRECT, assert pc_redirect=1, redirect_pc=EPC_out (current register value), flush_if=1, flush_id=1 for exactly one cycle, clear EXL at that edge, return to IDLE.
REQ-019 SHALL drive eret_busy=1 in DRAIN and REDIRECT; id_eret SHALL be ignored while busy.
REQ-020 SHALL, when exc_req=1 in DRAIN or REDIRECT, abort to IDLE with no pc_redirect and no EXL clear; exception update per REQ-013 applies.
REQ-021 SHALL, when id_eret and exc_req both 1 in IDLE, take the exception only; ERET discarded.
REQ-022 SHALL use the updated EPC if mtc0 writes EPC during DRAIN (redirect reads register at REDIRECT cycle).
REQ-023 SHALL execute ERET regardless of EXL value (EXL=0 stays 0).
REQ-024 SHALL keep pc_redirect, flush_id low in IDLE and DRAIN; redirect_pc = EPC_out at all times.

Reset
REQ-025 SHALL, when rst_n=0 at a clock edge, set state IDLE, counter 0, EPC=0, EXL=0, IE=0; all pulse outputs 0, eret_busy 0.
REQ-026 SHALL let reset mid-ERET (DRAIN/REDIRECT) abandon it with no redirect pulse.

Verification
REQ-027 SHALL cover: exc_req=1, epc_in=0x0040_0010 -> next cycle EPC_out=0x0040_0010, EXL=1, mfc0_data(addr 14)=0x0040_0010.
REQ-028 SHALL cover: EXL=1, EPC=0x0040_0010, id_eret pulse, no stall -> flush_if same cycle, pc_redirect=1 with redirect_pc=0x0040_0010 exactly 3 cycles later, EXL=0 after.
REQ-029 SHALL cover: ERET with stall=1 for 2 cycles in DRAIN -> pc_redirect delayed by exactly 2 cycles.
REQ-030 SHALL cover: exc_req asserted one cycle into DRAIN with epc_in=0x0000_0200 -> no pc_redirect, EPC=0x0000_0200, EXL=1, state IDLE.
REQ-031 SHALL cover: mtc0 write EPC=0x0000_1000 during DRAIN -> redirect_pc=0x0000_1000; mtc0 Status=0x3 -> EXL=1, IE=1.
REQ-032 SHALL cover: id_eret and exc_req same cycle -> exception taken, eret_busy stays 0, no redirect.

Source files
------------

// File: rtl/eret_ctrl.sv
// ERET sequencing controller with a minimal CP0 (Status/EPC) register file.
// An ERET decoded in ID flushes IF, drains the pipeline for a short count,
// then issues a single-cycle redirect to EPC and clears EXL.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no ERET in flight; accepts id_eret
// DRAIN    | waiting for older instructions; counter runs when not stalled
// REDIRECT | one-cycle return jump to EPC, flush IF/ID, clear EXL
module eret_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_eret,
    input  logic        exc_req,
    input  logic [31:0] epc_in,
    input  logic        stall,
    input  logic        mtc0_we,
    input  logic [4:0]  mtc0_addr,
    input  logic [31:0] mtc0_data,
    input  logic [4:0]  mfc0_addr,
    output logic [31:0] mfc0_data,
    output logic        EXL,
    output logic        IE,
    output logic [31:0] EPC_out,
    output logic        pc_redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_if,
    output logic        flush_id,
    output logic        eret_busy
);

    localparam logic [4:0] ADDR_STATUS = 5'd12;
    localparam logic [4:0] ADDR_EPC    = 5'd14;
    localparam logic [1:0] DRAIN_CNT   = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        eret_clr;
    logic [31:0] epc_q;
    logic        exl_q;
    logic        ie_q;

    // State register and drain counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and pulse outputs; an exception always aborts an ERET in flight
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        flush_if    = 1'b0;
        flush_id    = 1'b0;
        pc_redirect = 1'b0;
        eret_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (id_eret && !exc_req) begin
                    flush_if  = 1'b1;
                    state_nxt = DRAIN;
                    cnt_nxt   = DRAIN_CNT;
                end
            end
            DRAIN: begin
                if (exc_req) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 2'd0;
                end else if (!stall) begin
                    cnt_nxt = cnt - 2'd1;
                    if (cnt <= 2'd1) begin
                        state_nxt = REDIRECT;
                        cnt_nxt   = 2'd0;
                    end
                end
            end
            REDIRECT: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
                if (!exc_req) begin
                    pc_redirect = 1'b1;
                    flush_if    = 1'b1;
                    flush_id    = 1'b1;
                    eret_clr    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
        // Reset in the middle of an ERET must not leak a redirect pulse
        if (!rst_n) begin
            flush_if    = 1'b0;
            flush_id    = 1'b0;
            pc_redirect = 1'b0;
            eret_clr    = 1'b0;
        end
    end

    // CP0 registers; exception entry beats ERET EXL-clear beats mtc0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc_q <= 32'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
        end else if (exc_req) begin
            epc_q <= epc_in;
            exl_q <= 1'b1;
        end else begin
            if (mtc0_we && mtc0_addr == ADDR_STATUS) begin
                exl_q <= mtc0_data[1];
                ie_q  <= mtc0_data[0];
            end
            if (mtc0_we && mtc0_addr == ADDR_EPC) begin
                epc_q <= mtc0_data;
            end
            if (eret_clr) begin
                exl_q <= 1'b0;
            end
        end
    end

    // Combinational CP0 read port
    always_comb begin
        mfc0_data = 32'd0;
        case (mfc0_addr)
            ADDR_STATUS: mfc0_data = {30'd0, exl_q, ie_q};
            ADDR_EPC:    mfc0_data = epc_q;
            default:     mfc0_data = 32'd0;
        endcase
    end

    assign EXL         = exl_q;
    assign IE          = ie_q;
    assign EPC_out     = epc_q;
    assign redirect_pc = epc_q;
    assign eret_busy   = rst_n && (state != IDLE);

endmodule
